// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for the circuito_exp5 memory game:
// FSM state codes and the fixed 16-entry play sequence.
package circuito_exp5_pkg;

  // State codes double as the value shown on the state display
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h4,
    COMPARACAO  = 4'h5,
    PROXIMA     = 4'h6,
    FIM_ACERTOU = 4'hA,
    FIM_ERROU   = 4'hE
  } estado_t;

  localparam logic [3:0] ULTIMO_END = 4'hF;

  // Nibble i holds the expected play at address i
  localparam logic [63:0] ROM_SEQ = 64'h4188_4422_1124_8421;

  // Combinational ROM read
  function automatic logic [3:0] rom_ler(input logic [3:0] addr);
    return ROM_SEQ[{addr, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/circuito_exp5_hexa7seg.sv
// Hex digit to active-low 7-segment decoder.
// Output bit order is {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] hexa,
  output logic [6:0] sseg
);

  // Digit lookup; anything unexpected blanks the display
  always_comb begin
    sseg = 7'h7F;
    case (hexa)
      4'h0: sseg = 7'h40;
      4'h1: sseg = 7'h79;
      4'h2: sseg = 7'h24;
      4'h3: sseg = 7'h30;
      4'h4: sseg = 7'h19;
      4'h5: sseg = 7'h12;
      4'h6: sseg = 7'h02;
      4'h7: sseg = 7'h78;
      4'h8: sseg = 7'h00;
      4'h9: sseg = 7'h10;
      4'hA: sseg = 7'h08;
      4'hB: sseg = 7'h03;
      4'hC: sseg = 7'h46;
      4'hD: sseg = 7'h21;
      4'hE: sseg = 7'h06;
      4'hF: sseg = 7'h0E;
      default: sseg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/circuito_exp5.sv
// 16-play memory game: ROM, address counter, play register,
// comparator, play edge detector and Moore control FSM.
module circuito_exp5
  import circuito_exp5_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  output logic       acertou,
  output logic       errou,
  output logic       pronto,
  output logic [3:0] leds,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada
);

  estado_t    estado_q, estado_d;
  logic [3:0] contagem_q, contagem_d;
  logic [3:0] jogada_q, jogada_d;
  logic       hist_q, hist_d;
  logic       acertou_q, acertou_d;
  logic       errou_q, errou_d;
  logic       pronto_q, pronto_d;

  logic       jogada;
  logic       tem_jogada;
  logic [3:0] memoria;
  logic       igual;
  logic       fim_c;

  // Datapath combinational signals
  always_comb begin
    jogada     = |chaves;
    tem_jogada = jogada & ~hist_q;
    memoria    = rom_ler(contagem_q);
    igual      = (jogada_q == memoria);
    fim_c      = (contagem_q == ULTIMO_END);
  end

  // Next state, datapath control and Moore outputs
  always_comb begin
    estado_d   = estado_q;
    contagem_d = contagem_q;
    jogada_d   = jogada_q;
    hist_d     = jogada;
    case (estado_q)
      INICIAL: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      PREPARACAO: begin
        contagem_d = 4'h0;
        jogada_d   = 4'h0;
        estado_d   = ESPERA;
      end
      ESPERA: begin
        if (tem_jogada) estado_d = REGISTRA;
      end
      REGISTRA: begin
        jogada_d = chaves;
        estado_d = COMPARACAO;
      end
      COMPARACAO: begin
        if (!igual)     estado_d = FIM_ERROU;
        else if (fim_c) estado_d = FIM_ACERTOU;
        else            estado_d = PROXIMA;
      end
      PROXIMA: begin
        contagem_d = contagem_q + 4'h1;
        estado_d   = ESPERA;
      end
      FIM_ACERTOU, FIM_ERROU: begin
        if (iniciar) estado_d = PREPARACAO;
      end
      default: estado_d = INICIAL;
    endcase
    acertou_d = (estado_d == FIM_ACERTOU);
    errou_d   = (estado_d == FIM_ERROU);
    pronto_d  = acertou_d | errou_d;
  end

  // All state, with synchronous reset to the idle game
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= INICIAL;
      contagem_q <= 4'h0;
      jogada_q   <= 4'h0;
      hist_q     <= 1'b0;
      acertou_q  <= 1'b0;
      errou_q    <= 1'b0;
      pronto_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      contagem_q <= contagem_d;
      jogada_q   <= jogada_d;
      hist_q     <= hist_d;
      acertou_q  <= acertou_d;
      errou_q    <= errou_d;
      pronto_q   <= pronto_d;
    end
  end

  assign acertou       = acertou_q;
  assign errou         = errou_q;
  assign pronto        = pronto_q;
  assign leds          = chaves;
  assign db_igual      = igual;
  assign db_clock      = clock;
  assign db_iniciar    = iniciar;
  assign db_tem_jogada = tem_jogada;

  hexa7seg u_hex_cont (
    .hexa (contagem_q),
    .sseg (db_contagem)
  );

  hexa7seg u_hex_mem (
    .hexa (memoria),
    .sseg (db_memoria)
  );

  hexa7seg u_hex_est (
    .hexa (estado_q),
    .sseg (db_estado)
  );

  hexa7seg u_hex_jog (
    .hexa (jogada_q),
    .sseg (db_jogadafeita)
  );

endmodule

// File: tb/tb_circuito_exp5.sv
// Scoreboard bench for circuito_exp5: game outcomes are queued
// when a game is issued and checked when pronto rises.
module tb_circuito_exp5;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       acertou, errou, pronto;
  logic [3:0] leds;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria;
  logic [6:0] db_estado, db_jogadafeita;
  logic       db_clock, db_iniciar, db_tem_jogada;

  circuito_exp5 dut (
    .clock          (clock),
    .reset          (reset),
    .iniciar        (iniciar),
    .chaves         (chaves),
    .acertou        (acertou),
    .errou          (errou),
    .pronto         (pronto),
    .leds           (leds),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_clock       (db_clock),
    .db_iniciar     (db_iniciar),
    .db_tem_jogada  (db_tem_jogada)
  );

  always #5 clock = ~clock;

  typedef struct {
    int acertou;
    int errou;
    int estado;
    int contagem;
    int pulsos;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   rom_seq [16] = '{1, 2, 4, 8, 4, 2, 1, 1, 2, 2, 4, 4, 8, 8, 1, 4};
  int   pulsos = 0;
  logic pronto_prev = 1'b0;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  15: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (seg(i) == s) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic play(input logic [3:0] v, input int hold, input int idle);
    chaves = v;
    cyc(hold);
    chaves = 4'h0;
    cyc(idle);
  endtask

  task automatic wait_pronto();
    int t = 0;
    while (!pronto && t < 300) begin
      cyc(1);
      t++;
    end
    if (!pronto) chk("timeout_pronto", 0, 1);
  endtask

  // k < 16: play k correct entries then a wrong one; k >= 16: full run
  task automatic run_game(input int k, input bit rnd);
    exp_t       e;
    int         n;
    logic [3:0] v;
    if (k >= 16) begin
      e = '{1, 0, 10, 15, 16};
      n = 16;
    end else begin
      e = '{0, 1, 14, k, k + 1};
      n = k + 1;
    end
    sb.push_back(e);
    iniciar = 1'b1;
    cyc(5);
    iniciar = 1'b0;
    cyc(1);
    for (int i = 0; i < n; i++) begin
      v = 4'(rom_seq[i]);
      if (i == k) begin
        do v = 4'b0001 << $urandom_range(0, 3);
        while (v == 4'(rom_seq[i]));
      end
      if (rnd) play(v, $urandom_range(2, 12), $urandom_range(3, 12));
      else     play(v, 10, 10);
    end
    wait_pronto();
  endtask

  // Monitor: count edge pulses per game and score each outcome
  always @(negedge clock) begin
    if (reset) begin
      pulsos      = 0;
      pronto_prev = 1'b0;
    end else begin
      if (db_estado == seg(1)) pulsos = 0;
      if (db_tem_jogada === 1'b1) pulsos++;
      if (pronto === 1'b1 && !pronto_prev) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_end", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("end_acertou", int'(acertou), e.acertou);
          chk("end_errou", int'(errou), e.errou);
          chk("end_estado", dec(db_estado), e.estado);
          chk("end_contagem", dec(db_contagem), e.contagem);
          chk("end_pulsos", pulsos, e.pulsos);
        end
      end
      pronto_prev = (pronto === 1'b1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sts [5];
    reset   = 1'b1;
    iniciar = 1'b0;
    chaves  = 4'h0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_estado", dec(db_estado), 0);
    chk("rst_acertou", int'(acertou), 0);
    chk("rst_errou", int'(errou), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_contagem", dec(db_contagem), 0);
    chk("rst_jogada", dec(db_jogadafeita), 0);
    chk("rst_igual", int'(db_igual), 0);
    chk("rst_memoria", dec(db_memoria), 1);

    iniciar = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      sts[i] = dec(db_estado);
    end
    iniciar = 1'b0;
    chk("ini_estado0", sts[0], 1);
    chk("ini_estado1", sts[1], 2);
    chk("ini_estado4", sts[4], 2);
    chk("ini_contagem", dec(db_contagem), 0);

    chaves = 4'b0100;
    #1;
    chk("leds_copy", int'(leds), 4);
    chaves = 4'h0;
    cyc(2);

    run_game(16, 1'b0);
    chk("full_acertou", int'(acertou), 1);
    chk("full_errou", int'(errou), 0);
    cyc(3);
    chk("full_hold", dec(db_estado), 10);

    iniciar = 1'b1;
    cyc(5);
    iniciar = 1'b0;
    chk("restart_pronto", int'(pronto), 0);
    chk("restart_acertou", int'(acertou), 0);
    chk("restart_estado", dec(db_estado), 2);
    chk("restart_contagem", dec(db_contagem), 0);

    run_game(4, 1'b0);

    iniciar = 1'b1;
    cyc(5);
    iniciar = 1'b0;
    cyc(1);
    for (int i = 0; i < 7; i++) play(4'(rom_seq[i]), 10, 10);
    chk("mid_estado", dec(db_estado), 2);
    chk("mid_contagem", dec(db_contagem), 7);
    chk("mid_memoria", dec(db_memoria), rom_seq[7]);
    reset = 1'b1;
    cyc(5);
    reset = 1'b0;
    chk("midrst_estado", dec(db_estado), 0);
    chk("midrst_contagem", dec(db_contagem), 0);
    chk("midrst_jogada", dec(db_jogadafeita), 0);
    chk("midrst_pronto", int'(pronto), 0);
    chk("midrst_acertou", int'(acertou), 0);
    chk("midrst_errou", int'(errou), 0);

    for (int g = 0; g < 20; g++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? 16 : int'($urandom_range(0, 15));
      run_game(k, 1'b1);
    end

    cyc(3);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
